minibit_io_port: RTL and testbench

- Console I/O responder on the far side of the CPU sequencer's `tx`/`hlt`/`rx` interface.
- Input: when the CPU stalls on a read (`hlt` high), the block drives one byte from its input FIFO onto the shared bus, then pulses `rx` so the sequencer timer advances.
- Output: when the CPU strobes `tx` during a display instruction, the block captures the bus byte into an output FIFO that the host console drains.

---
 rtl/minibit_io_port.sv | 167 ++++++++++++++++
 tb/tb_minibit_io_port.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/minibit_io_port.sv
// minibit_io_port: console I/O responder for the CPU sequencer.
// Input path: keyboard bytes queue in an input FIFO. When the CPU halts
// waiting for input, the oldest byte goes onto the shared bus and rx is
// pulsed for one cycle.
// Output path: a rising edge on tx captures the bus byte into an output
// FIFO, which the host console drains.
//
// Input FSM states
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | bus released, waiting for hlt with a byte available
//   ST_DRIVE   | one cycle: drive FIFO head, pulse rx, pop input FIFO
//   ST_RELEASE | keep driving the latched byte until hlt drops
module minibit_io_port #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire  [7:0] bus,
    input  logic       hlt,
    input  logic       tx,
    output logic       rx,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow
);

    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_RELEASE
    } state_t;

    state_t state, state_nx;

    // input FIFO
    logic [7:0]    in_mem [DEPTH];
    logic [AW-1:0] in_wr, in_rd;
    logic [AW:0]   in_cnt;
    logic          in_full, in_empty, in_push, in_pop;
    logic [7:0]    in_head;

    // output FIFO
    logic [7:0]    out_mem [DEPTH];
    logic [AW-1:0] out_wr, out_rd;
    logic [AW:0]   out_cnt;
    logic          out_full, out_empty, out_push, out_pop;

    logic          tx_q, capture;
    logic [7:0]    hold_q;
    logic          bus_en;
    logic [7:0]    bus_val;

    assign in_full  = (in_cnt == CNT_FULL);
    assign in_empty = (in_cnt == '0);
    assign in_ready = ~in_full;
    assign in_push  = in_valid & ~in_full;
    // DRIVE is only entered with a byte present, and nothing else pops,
    // so the pop below never underflows.
    assign in_pop   = (state == ST_DRIVE);
    assign in_head  = in_mem[in_rd];

    assign out_full  = (out_cnt == CNT_FULL);
    assign out_empty = (out_cnt == '0);
    assign out_valid = ~out_empty;
    assign out_data  = out_mem[out_rd];
    assign out_pop   = out_valid & out_ready;
    assign capture   = tx & ~tx_q;
    // A full FIFO still accepts the byte if the host frees a slot this cycle.
    assign out_push  = capture & (~out_full | out_pop);

    // Input FIFO storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) in_mem[i] <= '0;
            in_wr  <= '0;
            in_rd  <= '0;
            in_cnt <= '0;
        end else begin
            if (in_push) begin
                in_mem[in_wr] <= in_data;
                in_wr         <= in_wr + 1'b1;
            end
            if (in_pop) in_rd <= in_rd + 1'b1;
            case ({in_push, in_pop})
                2'b10:   in_cnt <= in_cnt + 1'b1;
                2'b01:   in_cnt <= in_cnt - 1'b1;
                default: in_cnt <= in_cnt;
            endcase
        end
    end

    // Output FIFO storage, pointers, occupancy count and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) out_mem[i] <= '0;
            out_wr   <= '0;
            out_rd   <= '0;
            out_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (out_push) begin
                out_mem[out_wr] <= bus;
                out_wr          <= out_wr + 1'b1;
            end
            if (out_pop) out_rd <= out_rd + 1'b1;
            case ({out_push, out_pop})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
            if (capture & ~out_push) overflow <= 1'b1;
        end
    end

    // tx edge detector register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_q <= 1'b0;
        else     tx_q <= tx;
    end

    // Input FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Latch the byte leaving the FIFO so RELEASE can keep driving it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    hold_q <= '0;
        else if (state == ST_DRIVE) hold_q <= in_head;
    end

    // Input FSM next state and bus/rx outputs.
    always_comb begin
        state_nx = state;
        rx       = 1'b0;
        bus_en   = 1'b0;
        bus_val  = hold_q;
        unique case (state)
            ST_IDLE: begin
                if (hlt && !in_empty) state_nx = ST_DRIVE;
            end
            ST_DRIVE: begin
                rx       = 1'b1;
                bus_en   = 1'b1;
                bus_val  = in_head;
                state_nx = ST_RELEASE;
            end
            ST_RELEASE: begin
                bus_en = 1'b1;
                if (!hlt) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus = bus_en ? bus_val : 8'hzz;

endmodule

// File: tb/tb_minibit_io_port.sv
// Self-checking bench for minibit_io_port. Expected bytes are queued when
// stimulus is applied; a negedge monitor pops and compares them whenever
// the DUT sources an input byte (rx) or hands an output byte to the host.
module tb_minibit_io_port;

    logic       clk = 1'b0;
    logic       rst;
    wire  [7:0] bus;
    logic       hlt, tx, rx;
    logic [7:0] in_data;
    logic       in_valid, in_ready;
    logic [7:0] out_data;
    logic       out_valid, out_ready, overflow;

    logic       tb_drv_en;
    logic [7:0] tb_drv_val;

    int n_checks = 0;
    int n_pass   = 0;
    int rx_cnt   = 0;
    int out_pops = 0;

    logic [7:0] in_q[$];
    logic [7:0] out_q[$];

    typedef struct {
        logic [7:0] data;
        logic       flag;
    } vec_t;

    vec_t in_vec[4];
    vec_t tx_vec[5];

    // The released bus floats to the pull-up, so an idle bus reads 8'hFF.
    assign bus = tb_drv_en ? tb_drv_val : 8'hzz;
    pullup (bus);

    always #5 clk = ~clk;

    minibit_io_port #(.DEPTH(4), .AW(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .hlt      (hlt),
        .tx       (tx),
        .rx       (rx),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overflow (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_in(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        in_q.push_back(d);
        tick();
        in_valid = 1'b0;
    endtask

    // Raise hlt, wait (bounded) for the rx pulse, then drop hlt and let
    // the FSM return to IDLE.
    task automatic do_halt(input string name);
        bit seen = 0;
        hlt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rx) begin
                seen = 1;
                break;
            end
        end
        check({name, "_rx_seen"}, 32'(seen), 32'd1);
        hlt = 1'b0;
        tick();
        tick();
        check({name, "_bus_released"}, 32'(bus), 32'hFF);
    endtask

    task automatic tx_strobe(input logic [7:0] d);
        tb_drv_en  = 1'b1;
        tb_drv_val = d;
        tx         = 1'b1;
        tick();
        tx = 1'b0;
        tick();
        tb_drv_en = 1'b0;
    endtask

    task automatic drain_out(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 12 && out_valid; i++) tick();
        check({name, "_drained"}, 32'(out_valid), 32'd0);
        out_ready = 1'b0;
    endtask

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst && rx === 1'b1) begin
            rx_cnt++;
            if (in_q.size() == 0) check("in_sb_unexpected_rx", 32'(bus), 32'h0);
            else                  check("in_sb_bus", 32'(bus), 32'(in_q.pop_front()));
        end
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            out_pops++;
            if (out_q.size() == 0) check("out_sb_unexpected_pop", 32'(out_data), 32'h0);
            else                   check("out_sb_data", 32'(out_data), 32'(out_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rx_base, pop_base;
        in_vec[0] = '{8'h01, 1'b1};
        in_vec[1] = '{8'h02, 1'b1};
        in_vec[2] = '{8'h03, 1'b1};
        in_vec[3] = '{8'h04, 1'b0};
        tx_vec[0] = '{8'h10, 1'b1};
        tx_vec[1] = '{8'h11, 1'b1};
        tx_vec[2] = '{8'h12, 1'b1};
        tx_vec[3] = '{8'h13, 1'b1};
        tx_vec[4] = '{8'h14, 1'b0};

        rst = 1'b1; hlt = 1'b0; tx = 1'b0; in_data = '0; in_valid = 1'b0;
        out_ready = 1'b0; tb_drv_en = 1'b0; tb_drv_val = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // reset state
        check("rst_rx", 32'(rx), 32'd0);
        check("rst_bus", 32'(bus), 32'hFF);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_overflow", 32'(overflow), 32'd0);

        // single byte, hlt held 3 cycles
        rx_base = rx_cnt;
        push_in(8'h41);
        hlt = 1'b1;
        tick();
        check("t2_rx_cycle1", 32'(rx), 32'd1);
        check("t2_bus_drive", 32'(bus), 32'h41);
        tick();
        check("t2_rx_cycle2", 32'(rx), 32'd0);
        check("t2_bus_rel1", 32'(bus), 32'h41);
        tick();
        check("t2_rx_cycle3", 32'(rx), 32'd0);
        check("t2_bus_rel2", 32'(bus), 32'h41);
        hlt = 1'b0;
        tick();
        check("t2_bus_idle", 32'(bus), 32'hFF);
        check("t2_rx_count", 32'(rx_cnt - rx_base), 32'd1);
        hlt = 1'b1;
        repeat (4) tick();
        hlt = 1'b0;
        tick();
        check("t2_empty_no_rx", 32'(rx_cnt - rx_base), 32'd1);

        // hlt waits on empty FIFO, byte arrives later
        rx_base = rx_cnt;
        hlt = 1'b1;
        repeat (5) tick();
        check("t3_stalled", 32'(rx_cnt - rx_base), 32'd0);
        push_in(8'h7F);
        check("t3_rx_after_push", 32'(rx), 32'd0);
        tick();
        check("t3_rx_2nd", 32'(rx), 32'd1);
        check("t3_bus", 32'(bus), 32'h7F);
        hlt = 1'b0;
        tick();
        check("t3_bus_hold", 32'(bus), 32'h7F);
        tick();
        check("t3_bus_idle", 32'(bus), 32'hFF);

        // fill input FIFO, drain in order, then wrap
        foreach (in_vec[i]) begin
            push_in(in_vec[i].data);
            check($sformatf("t4_in_ready_%0d", i), 32'(in_ready), 32'(in_vec[i].flag));
        end
        for (int i = 0; i < 4; i++) do_halt($sformatf("t4_halt%0d", i));
        check("t4_in_ready_empty", 32'(in_ready), 32'd1);
        push_in(8'h05);
        do_halt("t4_wrap");

        // output FIFO fill and overflow
        foreach (tx_vec[i]) begin
            if (tx_vec[i].flag) out_q.push_back(tx_vec[i].data);
            tx_strobe(tx_vec[i].data);
            check($sformatf("t5_overflow_%0d", i), 32'(overflow), 32'(!tx_vec[i].flag));
        end
        check("t5_out_valid", 32'(out_valid), 32'd1);
        pop_base = out_pops;
        drain_out("t5");
        check("t5_pops", 32'(out_pops - pop_base), 32'd4);

        // tx held high captures once
        tb_drv_en = 1'b1; tb_drv_val = 8'h55; tx = 1'b1;
        out_q.push_back(8'h55);
        repeat (3) tick();
        tx = 1'b0;
        tick();
        tb_drv_en = 1'b0;
        pop_base = out_pops;
        drain_out("t5_hold");
        check("t5_hold_pops", 32'(out_pops - pop_base), 32'd1);
        check("t5_overflow_sticky", 32'(overflow), 32'd1);

        // full output FIFO with simultaneous host pop accepts the byte
        for (int i = 0; i < 4; i++) begin
            out_q.push_back(8'hA0 + 8'(i));
            tx_strobe(8'hA0 + 8'(i));
        end
        pop_base = out_pops;
        tb_drv_en = 1'b1; tb_drv_val = 8'hA4; tx = 1'b1; out_ready = 1'b1;
        out_q.push_back(8'hA4);
        tick();
        tx = 1'b0; tb_drv_en = 1'b0;
        drain_out("t5_fullpop");
        check("t5_fullpop_pops", 32'(out_pops - pop_base), 32'd5);

        // reset during RELEASE
        tx_strobe(8'h77);
        push_in(8'h66);
        push_in(8'h67);
        hlt = 1'b1;
        tick();
        tick();
        check("t6_in_release", 32'(bus), 32'h66);
        #1 rst = 1'b1;
        #1;
        check("t6_bus_z", 32'(bus), 32'hFF);
        check("t6_rx", 32'(rx), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_overflow", 32'(overflow), 32'd0);
        in_q.delete();
        out_q.delete();
        tick();
        rst = 1'b0;
        rx_base = rx_cnt;
        repeat (4) tick();
        check("t6_fifo_empty_no_rx", 32'(rx_cnt - rx_base), 32'd0);
        hlt = 1'b0;
        tick();

        check("sb_in_empty", 32'(in_q.size()), 32'd0);
        check("sb_out_empty", 32'(out_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
